// File: rtl/audio_avg_filter.sv
// Moving-average noise filter for one audio channel.
// Each accepted sample is pre-scaled by 1/N and kept in a circular buffer.
// A running accumulator holds the sum of the last N scaled samples.
// Ports:
//   CLOCK_50   - sole clock, rising edge
//   reset_n    - asynchronous active-low reset
//   en         - sample strobe, one cycle per sample
//   flush      - synchronous clear of the window; wins over en
//   din        - signed input sample, sampled when en=1
//   dout       - signed filtered sample, registered, holds between updates
//   dout_valid - one-cycle pulse when dout has been updated
//   filled     - high once N samples are in the window since reset/flush
module audio_avg_filter #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned LOG2_N     = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  filled
);

    localparam int unsigned N     = 1 << LOG2_N;
    localparam int unsigned CNT_W = LOG2_N + 1;
    localparam int unsigned ACC_W = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        FULL
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LOG2_N-1:0]       wptr_q, wptr_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] acc_sum;
    logic [DATA_WIDTH-1:0]   dout_d;
    logic                    valid_d;
    logic                    filled_d;
    logic                    accept;

    logic signed [DATA_WIDTH-1:0] sample_buf [N];
    logic signed [DATA_WIDTH-1:0] scaled;
    logic signed [DATA_WIDTH-1:0] oldest;

    // Flush discards a coincident sample.
    assign accept = en & ~flush;

    // Arithmetic shift floors toward minus infinity.
    assign scaled = $signed(din) >>> LOG2_N;
    assign oldest = sample_buf[wptr_q];

    // Add newest, evict oldest; the extra bit absorbs the intermediate value.
    assign acc_sum = acc_q + {scaled[DATA_WIDTH-1], scaled} - {oldest[DATA_WIDTH-1], oldest};

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wptr_d   = wptr_q;
        acc_d    = acc_q;
        dout_d   = dout;
        valid_d  = 1'b0;

        if (flush) begin
            state_d = EMPTY;
            cnt_d   = '0;
            wptr_d  = '0;
            acc_d   = '0;
            dout_d  = '0;
        end else if (accept) begin
            wptr_d  = wptr_q + LOG2_N'(1);
            acc_d   = acc_sum;
            dout_d  = acc_sum[DATA_WIDTH-1:0];
            valid_d = 1'b1;
            case (state_q)
                EMPTY, FILL: begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_d == CNT_W'(N)) ? FULL : FILL;
                end
                default: ;
            endcase
        end

        filled_d = (state_d == FULL);
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            cnt_q      <= '0;
            wptr_q     <= '0;
            acc_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            filled     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            acc_q      <= acc_d;
            dout       <= dout_d;
            dout_valid <= valid_d;
            filled     <= filled_d;
        end
    end

    // Window storage; entries start at zero so filling is zero-padded.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(N); i++) sample_buf[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < int'(N); i++) sample_buf[i] <= '0;
        end else if (accept) begin
            sample_buf[wptr_q] <= scaled;
        end
    end

endmodule

// File: tb/tb_audio_avg_filter.sv
// Scoreboard bench for audio_avg_filter (N=8, DATA_WIDTH=24).
module tb_audio_avg_filter;

    localparam int unsigned DW = 24;
    localparam int unsigned LN = 3;
    localparam int unsigned N  = 8;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n  = 1'b0;
    logic          en       = 1'b0;
    logic          flush    = 1'b0;
    logic [DW-1:0] din      = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          filled;

    audio_avg_filter #(.DATA_WIDTH(DW), .LOG2_N(LN)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .en         (en),
        .flush      (flush),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .filled     (filled)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          f;
        int            c;
    } exp_t;

    exp_t sb[$];
    int   hist[$];   // scaled samples currently in the reference window

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per dout_valid pulse.
    always @(negedge CLOCK_50) begin
        if (reset_n) begin
            if (dout_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", DW'(dout_valid), '0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("dout", dout, e.d);
                    check("filled_at_valid", DW'(filled), DW'(e.f));
                    check("latency_cycle", DW'(cyc), DW'(e.c));
                end
            end else if (sb.size() > 0 && sb[0].c <= cyc) begin
                check("missing_valid", DW'(dout_valid), DW'(1));
                void'(sb.pop_front());
            end
        end
    end

    // Drive one cycle of inputs and update the reference model.
    task automatic drive(input logic e, input logic fl, input logic [DW-1:0] d);
        int   sum;
        exp_t x;
        @(negedge CLOCK_50);
        en    = e;
        flush = fl;
        din   = d;
        if (fl) begin
            hist.delete();
        end else if (e) begin
            hist.push_back(int'($signed(d)) >>> LN);
            if (hist.size() > N) void'(hist.pop_front());
            sum = 0;
            foreach (hist[i]) sum += hist[i];
            x.d = DW'(sum);
            x.f = (hist.size() == N);
            x.c = cyc + 1;
            sb.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0);
    endtask

    task automatic strobes(input int n, input logic [DW-1:0] d, input int gap);
        repeat (n) begin
            drive(1'b1, 1'b0, d);
            if (gap > 0) idle(gap);
        end
    endtask

    // Reset asserted mid-cycle, held about 3 cycles.
    task automatic do_reset();
        @(negedge CLOCK_50);
        #3 reset_n = 1'b0;
        en    = 1'b0;
        flush = 1'b0;
        #1;
        check("rst_dout", dout, '0);
        check("rst_valid", DW'(dout_valid), '0);
        check("rst_filled", DW'(filled), '0);
        sb.delete();
        hist.delete();
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and quiet period.
        do_reset();
        idle(5);
        check("idle_dout", dout, '0);

        // Fill ramp with gaps, then a 9th sample.
        strobes(7, DW'(800), 3);
        check("filled_before_8th", DW'(filled), '0);
        strobes(1, DW'(800), 3);
        check("ramp_final", dout, DW'(800));
        check("ramp_filled", DW'(filled), DW'(1));
        strobes(1, DW'(800), 2);

        // Drain with back-to-back zeros, two wraps.
        strobes(16, '0, 0);
        idle(2);
        check("drain_zero", dout, '0);

        // Sign and extremes.
        strobes(8, 24'hFFFFFF, 0);
        idle(2);
        check("minus_one", dout, 24'hFFFFF8);
        strobes(8, 24'h7FFFFF, 0);
        idle(2);
        check("max_pos", dout, 24'h7FFFF8);
        strobes(8, 24'h800000, 0);
        idle(2);
        check("max_neg", dout, 24'h800000);
        repeat (16) begin
            strobes(1, 24'h7FFFFF, 0);
            strobes(1, 24'h800000, 0);
        end
        idle(2);

        // Flush collides with en.
        strobes(8, DW'(800), 0);
        drive(1'b1, 1'b1, DW'(400));
        idle(1);
        check("flush_dout", dout, '0);
        check("flush_valid", DW'(dout_valid), '0);
        check("flush_filled", DW'(filled), '0);
        strobes(1, DW'(400), 2);
        check("post_flush", dout, DW'(50));

        // Reset mid-stream.
        do_reset();
        strobes(5, DW'(800), 0);
        idle(2);
        check("pre_reset", dout, DW'(500));
        do_reset();
        strobes(1, DW'(800), 2);
        check("post_reset", dout, DW'(100));
        check("post_reset_filled", DW'(filled), '0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            logic fl;
            fl = ($urandom_range(0, 19) == 0);
            drive(1'($urandom_range(0, 1)) | 1'(i % 3 == 0), fl, DW'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(4);
        check("sb_drained", DW'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
